// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants and helpers for the single-clock flexible FIFO.
//   FIFO_MODE_STD / FIFO_MODE_FWFT : values for the FWFT parameter
//   fifo_widths()                  : pointer and count widths for a depth
//   fifo_ptr_inc()                 : pointer increment with wrap at depth-1
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  typedef struct packed {
    int unsigned ptr_w;
    int unsigned cnt_w;
  } fifo_widths_t;

  // Pointers index 0..depth-1; the count must also represent depth itself.
  function automatic fifo_widths_t fifo_widths(input int unsigned depth);
    fifo_widths_t w;
    w.ptr_w = (depth > 1) ? $clog2(depth) : 1;
    w.cnt_w = $clog2(depth + 1);
    return w;
  endfunction

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic int unsigned fifo_ptr_inc(input int unsigned ptr,
                                               input int unsigned depth);
    return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: DEPTH x DATA_WIDTH register array.
//   clk     : write clock (rising edge)
//   wr_en   : write strobe
//   wr_addr : write index (0..DEPTH-1)
//   wr_data : write data
//   rd_addr : read index (0..DEPTH-1)
//   rd_data : asynchronous read data
// Contents are intentionally not reset.
module fifo_mem #(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = 4
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_flex.sv
// fifo_sync_flex: single-clock FIFO, any depth >= 2, standard or FWFT read.
//   clk, rst          : clock (rising edge), async active-high reset
//   data_wr, wr_en    : write data / request
//   data_rd, rd_en    : read data / request (pop in FWFT mode)
//   fifo_full/empty   : count == DEPTH / count == 0
//   fifo_almost_full  : count >= AF_THRESH
//   fifo_almost_empty : count <= AE_THRESH
//   fifo_count        : current occupancy
//   clr_err, overflow, underflow : sticky error flags, present only when
//                       FIFO_ERR_FLAGS_EN is defined
module fifo_sync_flex
  import fifo_pkg::*;
#(
  parameter int DEPTH      = 12,
  parameter int DATA_WIDTH = 8,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        data_wr,
  input  logic                         wr_en,
  output logic                         fifo_full,
  output logic [DATA_WIDTH-1:0]        data_rd,
  input  logic                         rd_en,
  output logic                         fifo_empty,
  output logic                         fifo_almost_full,
  output logic                         fifo_almost_empty,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count
`ifdef FIFO_ERR_FLAGS_EN
  ,
  input  logic                         clr_err,
  output logic                         overflow,
  output logic                         underflow
`endif
);

  localparam fifo_widths_t WIDTHS = fifo_widths(DEPTH);
  localparam int PTR_W = int'(WIDTHS.ptr_w);
  localparam int CNT_W = int'(WIDTHS.cnt_w);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("fifo_sync_flex: DEPTH must be >= 2");
    end
    if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("fifo_sync_flex: AF_THRESH must be in 1..DEPTH");
    end
    if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("fifo_sync_flex: AE_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != FIFO_MODE_STD && FWFT != FIFO_MODE_FWFT) begin : g_bad_mode
      $error("fifo_sync_flex: FWFT must be 0 or 1");
    end
  endgenerate

  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_acc;
  logic                  wr_acc;
  logic [DATA_WIDTH-1:0] mem_rd;

  // Flags are pure decodes of the registered count.
  assign fifo_empty        = (cnt == '0);
  assign fifo_full         = (cnt == DEPTH_C);
  assign fifo_almost_full  = (cnt >= AF_C);
  assign fifo_almost_empty = (cnt <= AE_C);
  assign fifo_count        = cnt;

  // A read frees a slot in the same cycle, so a write at full is still
  // accepted when paired with a read.
  assign rd_acc = rd_en && !fifo_empty;
  assign wr_acc = wr_en && (!fifo_full || rd_acc);

  fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (data_wr),
    .rd_addr (rd_ptr),
    .rd_data (mem_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (wr_acc) wr_ptr <= PTR_W'(fifo_ptr_inc(32'(wr_ptr), DEPTH));
      if (rd_acc) rd_ptr <= PTR_W'(fifo_ptr_inc(32'(rd_ptr), DEPTH));
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is presented combinationally; zero when nothing is stored.
      assign data_rd = fifo_empty ? '0 : mem_rd;
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_q;
      // On a full-and-write cycle wr_ptr == rd_ptr; the non-blocking write
      // means rd_q still captures the old head word, as intended.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)         rd_q <= '0;
        else if (rd_acc) rd_q <= mem_rd;
      end
      assign data_rd = rd_q;
    end
  endgenerate

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_set;
  logic unf_set;

  // A read on an empty FIFO is an underflow even if a write lands with it.
  assign ovf_set = wr_en && fifo_full && !rd_acc;
  assign unf_set = rd_en && fifo_empty;

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (ovf_set)      overflow <= 1'b1;
      else if (clr_err) overflow <= 1'b0;
      if (unf_set)      underflow <= 1'b1;
      else if (clr_err) underflow <= 1'b0;
    end
  end
`endif

endmodule

// File: doc/fifo_sync_flex.md
# fifo_sync_flex

Single-clock, parametrised successor to the dual-clock `fifo`. It supports any depth, including non-power-of-2, and selects standard or first-word-fall-through (FWFT) read mode at elaboration. It adds programmable almost-full/almost-empty thresholds, a live fill count and optional sticky overflow/underflow error flags. It sits between producer and consumer logic in one clock domain, where the CDC machinery of `fifo` is unnecessary.

## Interface
- `DEPTH`, 12: number of entries; ≥ 2; need not be a power of 2.
- `DATA_WIDTH`, 8: word width.
- `FWFT`, 0: 0 = standard registered read; 1 = first-word-fall-through.
- `AF_THRESH`, DEPTH-2: `fifo_almost_full` asserts at count ≥ AF_THRESH; range 1..DEPTH.
- `AE_THRESH`, 2: `fifo_almost_empty` asserts at count ≤ AE_THRESH; range 0..DEPTH-1.

Ports:
- `clk` input 1: single clock; all logic on the rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `data_wr` input DATA_WIDTH: write data.
- `wr_en` input 1: write request.
- `fifo_full` output 1: count == DEPTH.
- `data_rd` output DATA_WIDTH: read data.
- `rd_en` input 1: read request (FWFT: pop).
- `fifo_empty` output 1: count == 0.
- `fifo_almost_full` output 1: count ≥ AF_THRESH.
- `fifo_almost_empty` output 1: count ≤ AE_THRESH.
- `fifo_count` output $clog2(DEPTH+1): current occupancy.
- `clr_err` input 1: clears sticky error flags (FIFO_ERR_FLAGS_EN only).
- `overflow` output 1: sticky; a write was dropped (FIFO_ERR_FLAGS_EN only).
- `underflow` output 1: sticky; a read was issued while empty (FIFO_ERR_FLAGS_EN only).

## Operation
- Accepted write: `wr_en && (!fifo_full || rd_acc)`. Accepted read (`rd_acc`): `rd_en && !fifo_empty`.
- Accepted write stores `data_wr` at `wr_ptr`; `wr_ptr` advances.
- Accepted read advances `rd_ptr`.
- Pointers are $clog2(DEPTH) bits and wrap explicitly from DEPTH-1 to 0. There is no modulo-2^n wrap.
- Count update: +1 on write only, −1 on read only, unchanged for both or neither.
- Full plus simultaneous read and write: both are accepted and count stays DEPTH.
- Empty plus simultaneous read and write: the write is accepted and the read is ignored. This counts as an underflow.
- Write while full with no read: the word is dropped; pointers and count are unchanged.
- Read while empty: ignored; `data_rd` holds its value.
- Standard mode (FWFT=0): `data_rd` is a register loaded with `mem[rd_ptr]` on each accepted read and held otherwise.
- FWFT mode (FWFT=1): `data_rd` = `mem[rd_ptr]` while not empty, and 0 while empty. `rd_en` acknowledges the word presented and pops it.
- All flags decode from the registered count, so they change only on clock edges.
- Reset values: pointers 0, count 0, `data_rd` 0, `fifo_empty` 1, `fifo_full` 0, `fifo_almost_empty` 1, `fifo_almost_full` 0, `overflow` 0, `underflow` 0.
- Reset asserted mid-operation discards all contents immediately. Memory contents are not cleared.
- Elaboration fails on illegal parameters: `$error` if DEPTH < 2 or either threshold is out of range.

## Timing
- Write to visibility: a word written at edge N is readable from edge N (`fifo_empty` deasserts after N).
  - Standard: a read may be accepted at edge N+1; the word is on `data_rd` after N+1.
  - FWFT: the word is on `data_rd` after N, with no read needed.
- Standard read latency: 1 cycle. `rd_en` sampled at edge N gives new `data_rd` after edge N.
- Flags and `fifo_count` reflect all operations accepted at edge N, immediately after edge N.
- Sustained throughput: 1 write and 1 read per cycle.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined:
  - `overflow` sets on a dropped write; `underflow` sets on a read while empty.
  - Both stay set until `clr_err` or `rst`.
  - If `clr_err` and a new error occur in the same cycle, the error wins and the flag stays 1.
- Not defined: the `overflow`, `underflow` and `clr_err` ports are absent, and no error logic is built.

## Structure
- Package `fifo_pkg`:
  - localparams `FIFO_MODE_STD`=0 and `FIFO_MODE_FWFT`=1;
  - a function computing pointer width and count width from DEPTH;
  - a pointer-increment-with-wrap function.
- Sub-module `fifo_mem`: DEPTH×DATA_WIDTH register array with synchronous write and asynchronous read port.
- Control, count, flags and output register live in `fifo_sync_flex`.

## Test plan
All scenarios use DEPTH=12, DATA_WIDTH=8, AF=10, AE=2.
- Write 15 words after reset, then 15 reads:
  - `fifo_full` at count 12, and the last 3 writes are dropped;
  - data returns in order for 12 reads, then `fifo_empty`=1;
  - with FIFO_ERR_FLAGS_EN: `overflow`=1 and `underflow`=1.
- Threshold walk, 1 write per cycle from empty:
  - `fifo_almost_empty` drops when count goes 2→3;
  - `fifo_almost_full` rises when count goes 9→10;
  - reverse on reads.
- Wrap-around: 30 cycles of simultaneous rd/wr at count 5 with incrementing data 0..29. Count stays 5, reads return 0..24 in order, and pointers pass index 11→0 cleanly.
- Full plus simultaneous rd/wr: both are accepted, count stays 12, `overflow` stays 0. Empty plus simultaneous: count becomes 1 and `underflow`=1.
- FWFT=1: write 0xA5 to empty; `data_rd`=0xA5 the cycle after, with no `rd_en`. Pop gives `data_rd`=0 and `fifo_empty`=1.
- Assert `rst` at count 7 mid-burst. All outputs show reset values asynchronously, and the next write/read returns only new data.
